jstk_spi_shifter: RTL and testbench

- SPI mode-0 byte engine for the PmodJSTK2 interface; sits directly downstream of the transaction controller and consumes its SCLK-enable.
- Each enable window shifts one byte out on MOSI and one byte in from MISO, MSB first.
- Returns a per-byte valid pulse to the controller, and a level-held packet valid once NUM_BYTES bytes are assembled.

---
 rtl/jstk_spi_shifter.sv | 147 ++++++++++++++
 tb/tb_jstk_spi_shifter.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/jstk_spi_shifter.sv
// SPI mode-0 byte engine for the PmodJSTK2: one byte per SCLK-enable window,
// MSB first, with per-byte and per-packet valid flags back to the controller.
module jstk_spi_shifter #(
   parameter int CLK_DIV   = 50,
   parameter int NUM_BYTES = 5
) (
   input  logic                   i_clk,
   input  logic                   i_reset,
   input  logic                   i_load,
   input  logic [8*NUM_BYTES-1:0] i_tx_packet,
   input  logic                   i_sclk_enable,
   input  logic                   i_miso,
   output logic                   o_sclk,
   output logic                   o_mosi,
   output logic [7:0]             o_rx_byte,
   output logic                   o_rx_byte_valid,
   output logic [8*NUM_BYTES-1:0] o_rx_packet,
   output logic                   o_rx_packet_valid,
   output logic                   o_busy
);

   localparam int PW = 8 * NUM_BYTES;
   localparam int CW = $clog2(NUM_BYTES + 1);
   localparam logic [7:0]    HC_LAST  = 8'(CLK_DIV - 1);
   localparam logic [CW-1:0] CNT_FULL = CW'(NUM_BYTES);
   localparam logic [CW-1:0] CNT_LAST = CW'(NUM_BYTES - 1);

   typedef enum logic [2:0] {
      IDLE,
      SHIFT_LOW,
      SHIFT_HIGH,
      BYTE_END,
      RELEASE
   } state_t;

   state_t        state;
   logic [PW-1:0] tx_pkt;
   logic [7:0]    tx_sr;
   logic [7:0]    rx_sr;
   logic [7:0]    hcnt;
   logic [2:0]    bit_cnt;
   logic [CW-1:0] byte_cnt;
   logic [7:0]    tx_byte;

   always_comb begin
      tx_byte = '0;
      for (int i = 0; i < NUM_BYTES; i++) begin
         if (byte_cnt == CW'(i)) tx_byte = tx_pkt[PW-1-8*i -: 8];
      end
   end

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         state             <= IDLE;
         tx_pkt            <= '0;
         tx_sr             <= '0;
         rx_sr             <= '0;
         hcnt              <= '0;
         bit_cnt           <= '0;
         byte_cnt          <= '0;
         o_sclk            <= 1'b0;
         o_mosi            <= 1'b0;
         o_rx_byte         <= '0;
         o_rx_byte_valid   <= 1'b0;
         o_rx_packet       <= '0;
         o_rx_packet_valid <= 1'b0;
         o_busy            <= 1'b0;
      end else begin
         o_rx_byte_valid <= 1'b0;
         // a load wins over everything, including a byte completing now
         if (i_load) begin
            state             <= IDLE;
            tx_pkt            <= i_tx_packet;
            tx_sr             <= '0;
            rx_sr             <= '0;
            hcnt              <= '0;
            bit_cnt           <= '0;
            byte_cnt          <= '0;
            o_sclk            <= 1'b0;
            o_mosi            <= 1'b0;
            o_rx_packet_valid <= 1'b0;
            o_busy            <= 1'b0;
         end else begin
            case (state)
               IDLE: begin
                  if (i_sclk_enable && byte_cnt != CNT_FULL) begin
                     tx_sr   <= tx_byte;
                     o_mosi  <= tx_byte[7];
                     bit_cnt <= '0;
                     hcnt    <= '0;
                     state   <= SHIFT_LOW;
                     o_busy  <= 1'b1;
                  end
               end
               SHIFT_LOW: begin
                  if (hcnt == HC_LAST) begin
                     hcnt   <= '0;
                     o_sclk <= 1'b1;
                     rx_sr  <= {rx_sr[6:0], i_miso};
                     state  <= SHIFT_HIGH;
                  end else begin
                     hcnt <= hcnt + 8'd1;
                  end
               end
               SHIFT_HIGH: begin
                  if (hcnt == HC_LAST) begin
                     hcnt   <= '0;
                     o_sclk <= 1'b0;
                     if (bit_cnt == 3'd7) begin
                        state <= BYTE_END;
                     end else begin
                        bit_cnt <= bit_cnt + 3'd1;
                        tx_sr   <= {tx_sr[6:0], 1'b0};
                        o_mosi  <= tx_sr[6];
                        state   <= SHIFT_LOW;
                     end
                  end else begin
                     hcnt <= hcnt + 8'd1;
                  end
               end
               BYTE_END: begin
                  o_rx_byte       <= rx_sr;
                  o_rx_byte_valid <= 1'b1;
                  for (int i = 0; i < NUM_BYTES; i++) begin
                     if (byte_cnt == CW'(i)) o_rx_packet[PW-1-8*i -: 8] <= rx_sr;
                  end
                  if (byte_cnt != CNT_FULL) byte_cnt <= byte_cnt + CW'(1);
                  if (byte_cnt == CNT_LAST) o_rx_packet_valid <= 1'b1;
                  state <= RELEASE;
               end
               RELEASE: begin
                  // hold off until the controller drops its enable
                  if (!i_sclk_enable) begin
                     state  <= IDLE;
                     o_busy <= 1'b0;
                  end
               end
               default: begin
                  state  <= IDLE;
                  o_busy <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_jstk_spi_shifter.sv
// Scoreboard bench for jstk_spi_shifter: a MISO slave model feeds bytes,
// expected rx bytes are queued at enable time and popped on each valid pulse.
module tb_jstk_spi_shifter;

   localparam int CLK_DIV   = 2;
   localparam int NUM_BYTES = 5;
   localparam int PW        = 8 * NUM_BYTES;
   localparam int LAT       = 1 + 16 * CLK_DIV;

   logic          i_clk = 1'b0;
   logic          i_reset;
   logic          i_load;
   logic [PW-1:0] i_tx_packet;
   logic          i_sclk_enable;
   logic          i_miso;
   logic          o_sclk;
   logic          o_mosi;
   logic [7:0]    o_rx_byte;
   logic          o_rx_byte_valid;
   logic [PW-1:0] o_rx_packet;
   logic          o_rx_packet_valid;
   logic          o_busy;

   jstk_spi_shifter #(
      .CLK_DIV  (CLK_DIV),
      .NUM_BYTES(NUM_BYTES)
   ) dut (
      .i_clk            (i_clk),
      .i_reset          (i_reset),
      .i_load           (i_load),
      .i_tx_packet      (i_tx_packet),
      .i_sclk_enable    (i_sclk_enable),
      .i_miso           (i_miso),
      .o_sclk           (o_sclk),
      .o_mosi           (o_mosi),
      .o_rx_byte        (o_rx_byte),
      .o_rx_byte_valid  (o_rx_byte_valid),
      .o_rx_packet      (o_rx_packet),
      .o_rx_packet_valid(o_rx_packet_valid),
      .o_busy           (o_busy)
   );

   always #5 i_clk = ~i_clk;

   int         n_cmp = 0;
   int         n_err = 0;
   int         cyc = 0;
   int         vcnt = 0;
   int         vcyc = 0;
   logic       pv_at_v = 1'b0;
   int         rise_cnt = 0;
   logic [7:0] mosi_sr = '0;
   logic [7:0] miso_byte = '0;
   logic [2:0] midx;
   logic [7:0] exp_q[$];

   task automatic expect_eq(input string tag, input logic [63:0] obs,
                            input logic [63:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   always @(posedge i_clk) cyc++;

   // slave model: bit for the next rise is presented after each rise
   always @(posedge o_sclk) begin
      rise_cnt++;
      mosi_sr = {mosi_sr[6:0], o_mosi};
   end

   always_comb begin
      midx   = 3'(7 - rise_cnt);
      i_miso = (rise_cnt < 8) ? miso_byte[midx] : 1'b0;
   end

   always @(negedge i_clk) begin
      if (!i_reset && o_rx_byte_valid) begin
         vcnt++;
         vcyc    = cyc;
         pv_at_v = o_rx_packet_valid;
         if (exp_q.size() > 0) expect_eq("rx_byte", o_rx_byte, exp_q.pop_front());
         else expect_eq("rx_unexp", o_rx_byte_valid, 1'b0);
      end
   end

   task automatic tick(input int n);
      repeat (n) @(negedge i_clk);
      #1;
   endtask

   task automatic load(input logic [PW-1:0] pkt);
      i_tx_packet = pkt;
      i_load      = 1'b1;
      tick(1);
      i_load = 1'b0;
   endtask

   task automatic wait_vc(input string tag, input int v0);
      for (int k = 0; k < 200 && vcnt == v0; k++) tick(1);
      expect_eq(tag, vcnt, v0 + 1);
   endtask

   task automatic wait_rise(input string tag, input int n);
      for (int k = 0; k < 300 && rise_cnt < n; k++) tick(1);
      expect_eq(tag, rise_cnt, n);
   endtask

   task automatic start_byte(input logic [7:0] miso);
      miso_byte     = miso;
      rise_cnt      = 0;
      mosi_sr       = '0;
      i_sclk_enable = 1'b1;
   endtask

   task automatic run_byte(input string tag, input logic [7:0] miso,
                           input logic [7:0] exp_mosi, input int hold);
      int v0;
      int st;
      v0 = vcnt;
      exp_q.push_back(miso);
      start_byte(miso);
      st = cyc + 1;
      tick(hold);
      i_sclk_enable = 1'b0;
      wait_vc({tag, "_done"}, v0);
      expect_eq({tag, "_lat"}, vcyc - st, LAT);
      tick(10);
      expect_eq({tag, "_rises"}, rise_cnt, 8);
      expect_eq({tag, "_mosi"}, mosi_sr, exp_mosi);
      expect_eq({tag, "_pulses"}, vcnt - v0, 1);
      expect_eq({tag, "_busy"}, o_busy, 1'b0);
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1);
   end

   logic [PW-1:0] pkt_b = 40'hC3_5A_F0_0F_81;
   logic [PW-1:0] pkt_q = 40'hE7_96_11_22_33;
   logic [7:0]    rxs[5] = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h9A};

   initial begin
      int v0;
      i_reset       = 1'b1;
      i_load        = 1'b0;
      i_tx_packet   = '0;
      i_sclk_enable = 1'b0;
      tick(3);
      expect_eq("rst_out", {o_sclk, o_mosi, o_rx_byte_valid, o_rx_packet_valid, o_busy}, 5'b0);
      expect_eq("rst_pkt", o_rx_packet, '0);
      expect_eq("rst_byte", o_rx_byte, '0);
      i_reset = 1'b0;
      tick(2);

      load(40'h84_00_FF_00_00);
      run_byte("single", 8'hA5, 8'h84, 40);

      load(pkt_b);
      for (int b = 0; b < NUM_BYTES; b++) begin
         if (b == NUM_BYTES - 1) expect_eq("pv_before_last", o_rx_packet_valid, 1'b0);
         run_byte($sformatf("pkt%0d", b), rxs[b], pkt_b[PW-1-8*b -: 8], 40);
      end
      expect_eq("pv_with_last", pv_at_v, 1'b1);
      expect_eq("pv_hold", o_rx_packet_valid, 1'b1);
      expect_eq("pkt_val", o_rx_packet, 40'h12_34_56_78_9A);

      v0 = vcnt;
      start_byte(8'hFF);
      tick(3);
      expect_eq("ovr_busy", o_busy, 1'b0);
      tick(20);
      i_sclk_enable = 1'b0;
      expect_eq("ovr_rises", rise_cnt, 0);
      expect_eq("ovr_pulses", vcnt - v0, 0);
      expect_eq("ovr_pv", o_rx_packet_valid, 1'b1);
      load(pkt_b);
      expect_eq("ld_pv", o_rx_packet_valid, 1'b0);
      expect_eq("ld_busy", o_busy, 1'b0);
      expect_eq("ld_keep_pkt", o_rx_packet, 40'h12_34_56_78_9A);

      load(40'h11_22_33_44_55);
      run_byte("ab0", 8'h01, 8'h11, 40);
      run_byte("ab1", 8'h02, 8'h22, 40);
      v0 = vcnt;
      start_byte(8'hF0);
      wait_rise("ab_rise5", 5);
      i_tx_packet   = pkt_q;
      i_load        = 1'b1;
      i_sclk_enable = 1'b0;
      tick(1);
      i_load = 1'b0;
      expect_eq("ab_sclk", o_sclk, 1'b0);
      expect_eq("ab_mosi", o_mosi, 1'b0);
      expect_eq("ab_busy", o_busy, 1'b0);
      tick(60);
      expect_eq("ab_pulses", vcnt - v0, 0);
      expect_eq("ab_rises", rise_cnt, 5);
      run_byte("ab_new", 8'h3C, 8'hE7, 40);
      expect_eq("ab_slot0", o_rx_packet[PW-1 -: 8], 8'h3C);

      v0 = vcnt;
      exp_q.push_back(8'h5B);
      start_byte(8'h5B);
      wait_rise("drop_rise3", 3);
      i_sclk_enable = 1'b0;
      wait_vc("drop_done", v0);
      tick(40);
      expect_eq("drop_rises", rise_cnt, 8);
      expect_eq("drop_mosi", mosi_sr, 8'h96);
      expect_eq("drop_pulses", vcnt - v0, 1);
      expect_eq("drop_busy", o_busy, 1'b0);

      start_byte(8'hC7);
      wait_rise("rst_rise4", 4);
      expect_eq("rst_pre_sclk", o_sclk, 1'b1);
      i_reset = 1'b1;
      #1;
      expect_eq("rst_mid", {o_sclk, o_mosi, o_rx_byte_valid, o_rx_packet_valid, o_busy}, 5'b0);
      i_sclk_enable = 1'b0;
      tick(3);
      i_reset = 1'b0;
      tick(2);
      run_byte("post_rst", 8'h69, 8'h00, 40);
      expect_eq("post_rst_pkt", o_rx_packet, {8'h69, 32'h0});

      expect_eq("sb_left", exp_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
